// File: rtl/uart_rx_vote_sampler.sv
`timescale 1ns/1ps
// uart_rx_vote_sampler
// Oversampling bit sampler for the UART receiver. It keeps its own edge counter
// inside each bit and takes a 1-, 3- or 5-sample majority vote centred on the
// middle of the bit. When the samples disagree it raises a noise flag. It also
// emits a bit-boundary pulse for the RX FSM.
//
// Ports:
//   CLK          oversampling clock
//   Reset        asynchronous, active-low reset
//   Prescale     oversampling ratio (edges per bit), latched on Bit_start
//   Vote_Mode    00 = 1 sample, 01 = 3, 10 = 5, 11 = DEF_VOTE; latched on Bit_start
//   S_Data       synchronised serial data
//   S_EN         sampler enable; when low, the block clears on every edge
//   Bit_start    one-cycle pulse that realigns the counter to a new bit
//   Edge_count   current edge index within the bit
//   Bit_done     one-cycle pulse at the bit boundary
//   Sampled      one-cycle pulse: Sampled_bit / Noise_err just updated
//   Sampled_bit  majority-voted bit, held until the next Sampled
//   Noise_err    samples disagreed, held with Sampled_bit
module uart_rx_vote_sampler #(
  parameter int         PRESCALE_W = 6,
  parameter logic [1:0] DEF_VOTE   = 2'b01
) (
  input  logic                  CLK,
  input  logic                  Reset,
  input  logic [PRESCALE_W-1:0] Prescale,
  input  logic [1:0]            Vote_Mode,
  input  logic                  S_Data,
  input  logic                  S_EN,
  input  logic                  Bit_start,
  output logic [PRESCALE_W-1:0] Edge_count,
  output logic                  Bit_done,
  output logic                  Sampled,
  output logic                  Sampled_bit,
  output logic                  Noise_err
);

  // One extra bit lets window arithmetic never wrap.
  localparam int CW = PRESCALE_W + 1;
  localparam logic [PRESCALE_W-1:0] MIN_PRESCALE = PRESCALE_W'(4);

  // ---------------------------------------------------------------------------
  // Configuration decode. This is evaluated every cycle but is only captured
  // on Bit_start.
  // ---------------------------------------------------------------------------
  logic [PRESCALE_W-1:0] prescale_in;
  logic [PRESCALE_W-1:0] center_in;
  logic [1:0]            mode_eff;
  logic [1:0]            h_req;
  logic [2:1]            h_fit;
  logic [1:0]            h_in;

  always_comb begin
    prescale_in = (Prescale < MIN_PRESCALE) ? MIN_PRESCALE : Prescale;
    center_in   = prescale_in >> 1;
    mode_eff    = (Vote_Mode == 2'b11) ? DEF_VOTE : Vote_Mode;
    case (mode_eff)
      2'b00:   h_req = 2'd0;
      2'b10:   h_req = 2'd2;
      default: h_req = 2'd1;
    endcase
  end

  // A half-width h fits when the whole window [C-h, C+h] lies inside the bit.
  // It must also leave at least one edge after the window, so that the
  // Sampled pulse always lands before the wrap.
  genvar gi;
  generate
    for (gi = 1; gi <= 2; gi++) begin : g_fit
      localparam logic [CW-1:0] H = CW'(gi);
      assign h_fit[gi] = ({1'b0, center_in} >= H) &&
                         (({1'b0, center_in} + H) <= ({1'b0, prescale_in} - CW'(2)));
    end
  endgenerate

  always_comb begin
    if (h_req == 2'd2 && h_fit[2])
      h_in = 2'd2;
    else if (h_req != 2'd0 && h_fit[1])
      h_in = 2'd1;
    else
      h_in = 2'd0;
  end

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [PRESCALE_W-1:0] prescale_reg, prescale_next;
  logic [1:0]            h_reg, h_next;
  logic [PRESCALE_W-1:0] edge_reg, edge_next;
  logic                  bit_done_reg, bit_done_next;
  logic                  sampled_reg, sampled_next;
  logic                  sampled_bit_reg, sampled_bit_next;
  logic                  noise_reg, noise_next;
  logic [4:0]            sample_sr_reg, sample_sr_next;
  logic [2:0]            ones_reg, ones_next;

  // Window decode on the latched configuration.
  logic [CW-1:0] center_ext, win_lo, win_hi, edge_ext;
  logic          in_window, at_decision, at_wrap;
  logic [2:0]    ones_total;

  always_comb begin
    center_ext  = {1'b0, prescale_reg >> 1};
    win_lo      = center_ext - CW'(h_reg);
    win_hi      = center_ext + CW'(h_reg);
    edge_ext    = {1'b0, edge_reg};
    in_window   = (edge_ext >= win_lo) && (edge_ext <= win_hi);
    at_decision = (edge_ext == win_hi);
    at_wrap     = (edge_reg == prescale_reg - PRESCALE_W'(1));
    // The decision includes the sample taken on this same edge.
    ones_total  = ones_reg + {2'b00, S_Data};
  end

  always_comb begin
    prescale_next    = prescale_reg;
    h_next           = h_reg;
    edge_next        = edge_reg;
    bit_done_next    = 1'b0;
    sampled_next     = 1'b0;
    sampled_bit_next = sampled_bit_reg;
    noise_next       = noise_reg;
    sample_sr_next   = sample_sr_reg;
    ones_next        = ones_reg;

    if (!S_EN) begin
      prescale_next    = '0;
      h_next           = '0;
      edge_next        = '0;
      sampled_bit_next = 1'b0;
      noise_next       = 1'b0;
      sample_sr_next   = '0;
      ones_next        = '0;
    end else if (Bit_start) begin
      // Bit_start overrides a coincident wrap, so no Bit_done is produced.
      prescale_next    = prescale_in;
      h_next           = h_in;
      edge_next        = '0;
      sampled_bit_next = 1'b0;
      noise_next       = 1'b0;
      sample_sr_next   = '0;
      ones_next        = '0;
    end else begin
      edge_next = edge_reg + PRESCALE_W'(1);

      if (in_window) begin
        sample_sr_next = {sample_sr_reg[3:0], S_Data};
        ones_next      = ones_total;
      end

      if (at_decision) begin
        sampled_next     = 1'b1;
        sampled_bit_next = (ones_total >= ({1'b0, h_reg} + 3'd1));
        noise_next       = (ones_total != 3'd0) && (ones_total != {h_reg, 1'b1});
      end

      // The window always ends before the last edge, so clearing here never
      // discards a pending decision.
      if (at_wrap) begin
        edge_next      = '0;
        bit_done_next  = 1'b1;
        sample_sr_next = '0;
        ones_next      = '0;
      end
    end
  end

  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      prescale_reg    <= '0;
      h_reg           <= '0;
      edge_reg        <= '0;
      bit_done_reg    <= 1'b0;
      sampled_reg     <= 1'b0;
      sampled_bit_reg <= 1'b0;
      noise_reg       <= 1'b0;
      sample_sr_reg   <= '0;
      ones_reg        <= '0;
    end else begin
      prescale_reg    <= prescale_next;
      h_reg           <= h_next;
      edge_reg        <= edge_next;
      bit_done_reg    <= bit_done_next;
      sampled_reg     <= sampled_next;
      sampled_bit_reg <= sampled_bit_next;
      noise_reg       <= noise_next;
      sample_sr_reg   <= sample_sr_next;
      ones_reg        <= ones_next;
    end
  end

  assign Edge_count  = edge_reg;
  assign Bit_done    = bit_done_reg;
  assign Sampled     = sampled_reg;
  assign Sampled_bit = sampled_bit_reg;
  assign Noise_err   = noise_reg;

endmodule
